ccff_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 24 ++
 rtl/ccff_loader_crc16.sv | 31 +++
 rtl/ccff_loader.sv | 180 ++++++++++++++++++
 tb/tb_ccff_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Latency: n/a (types, constants and a combinational CRC step helper).
// Backpressure: n/a.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // CRC-16-CCITT, MSB-first serial form
   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // One bit of a bit-serial CRC update
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/ccff_loader_crc16.sv
// Bit-serial CRC-16-CCITT accumulator (init 0xFFFF).
// Latency: o_crc reflects a bit the cycle after it is presented with i_en high.
// Backpressure: none; consumes a bit on every cycle i_en is high.
// Ports: i_clk/i_rst clock and async active-high reset, i_clr restarts the
//        CRC at its init value, i_en/i_bit present one data bit, o_crc value.
module ccff_crc16_serial
   import ccff_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_crc <= CRC_INIT;
      end else if (i_clr) begin
         r_crc <= CRC_INIT;
      end else if (i_en) begin
         r_crc <= crc16_step(r_crc, i_bit);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: bytes in over valid/ready, serialised MSB-first onto ccff_head with a gated chain clock.
// Latency: start -> din_ready next cycle; accepted byte -> its MSB on ccff_head next cycle at the earliest.
// Backpressure: din_ready drops while the holding byte is full or all needed bytes are taken; chain idles (clk_en=0) when starved.
// Ports: prog_clk/prog_reset clock and async active-high reset; start begins a load
//        from IDLE/DONE; din/din_valid/din_ready byte stream; ccff_head/ccff_tail/
//        ccff_clk_en chain interface; busy/done/error status.
// Build option: define CCFF_LOADER_READBACK_EN to add a CRC readback rotation (VERIFY).
module ccff_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic       prog_clk,
   input  logic       prog_reset,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       ccff_head,
   input  logic       ccff_tail,
   output logic       ccff_clk_en,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int NBYTES = (CHAIN_LEN + 7) / 8;
   localparam int BYTE_W = $clog2(NBYTES + 1);
   localparam logic [BYTE_W-1:0] BYTES_MAX = BYTE_W'(NBYTES);
   localparam logic [CNT_W-1:0]  BITS_MAX  = CNT_W'(CHAIN_LEN);

   state_t            r_state;
   logic [7:0]        r_hold;
   logic              r_hold_vld;
   logic [7:0]        r_sr;
   logic [3:0]        r_sr_cnt;     // unsent bits left in r_sr
   logic [BYTE_W-1:0] r_byte_cnt;
   logic [CNT_W-1:0]  r_bit_cnt;    // bits issued in LOAD, rotations in VERIFY
   logic              r_head;
   logic              r_clk_en;
   logic              r_busy;
   logic              r_done;
   logic              r_error;

   logic w_in_load, w_accept, w_need, w_have_sr, w_issue, w_bit, w_start_go;

   assign w_in_load  = (r_state == ST_LOAD);
   assign din_ready  = w_in_load && !r_hold_vld && (r_byte_cnt != BYTES_MAX);
   assign w_accept   = din_ready && din_valid;
   assign w_need     = w_in_load && (r_bit_cnt != BITS_MAX);
   assign w_have_sr  = (r_sr_cnt != 4'd0);
   // With both buffers empty an accepted byte bypasses straight to the output bit
   assign w_issue    = w_need && (w_have_sr || r_hold_vld || w_accept);
   assign w_bit      = w_have_sr ? r_sr[7] : (r_hold_vld ? r_hold[7] : din[7]);
   assign w_start_go = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef CCFF_LOADER_READBACK_EN
   localparam logic [CNT_W-1:0] ROT_LAST = CNT_W'(CHAIN_LEN - 1);
   logic [15:0] w_crc_ld, w_crc_rb;

   ccff_crc16_serial u_crc_ld (
      .i_clk (prog_clk),
      .i_rst (prog_reset),
      .i_clr (w_start_go),
      .i_en  (w_issue),
      .i_bit (w_bit),
      .o_crc (w_crc_ld)
   );

   ccff_crc16_serial u_crc_rb (
      .i_clk (prog_clk),
      .i_rst (prog_reset),
      .i_clr (w_start_go),
      .i_en  (r_state == ST_VERIFY),
      .i_bit (ccff_tail),
      .o_crc (w_crc_rb)
   );

   // Tail wired straight back to head while rotating so the chain is restored
   assign ccff_head = (r_state == ST_VERIFY) ? ccff_tail : r_head;
`else
   logic w_unused_tail;
   assign w_unused_tail = ccff_tail;
   assign ccff_head     = r_head;
`endif

   assign ccff_clk_en = r_clk_en;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_state    <= ST_IDLE;
         r_hold     <= 8'h00;
         r_hold_vld <= 1'b0;
         r_sr       <= 8'h00;
         r_sr_cnt   <= 4'd0;
         r_byte_cnt <= '0;
         r_bit_cnt  <= '0;
         r_head     <= 1'b0;
         r_clk_en   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state    <= ST_LOAD;
                  r_hold_vld <= 1'b0;
                  r_sr_cnt   <= 4'd0;
                  r_byte_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_clk_en   <= 1'b0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_accept) r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
               if (r_bit_cnt == BITS_MAX) begin
                  // last bit shifted at the end of this cycle; leftover bits dropped
`ifdef CCFF_LOADER_READBACK_EN
                  r_state   <= ST_VERIFY;
                  r_clk_en  <= 1'b1;
                  r_bit_cnt <= '0;
`else
                  r_state   <= ST_DONE;
                  r_clk_en  <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
`endif
               end else if (w_issue) begin
                  r_head    <= w_bit;
                  r_clk_en  <= 1'b1;
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (w_have_sr) begin
                     r_sr     <= {r_sr[6:0], 1'b0};
                     r_sr_cnt <= r_sr_cnt - 4'd1;
                     if (w_accept) begin
                        r_hold     <= din;
                        r_hold_vld <= 1'b1;
                     end
                  end else if (r_hold_vld) begin
                     r_sr       <= {r_hold[6:0], 1'b0};
                     r_sr_cnt   <= 4'd7;
                     r_hold_vld <= 1'b0;
                  end else begin
                     r_sr     <= {din[6:0], 1'b0};
                     r_sr_cnt <= 4'd7;
                  end
               end else begin
                  // starved: chain holds, head keeps its last value
                  r_clk_en <= 1'b0;
               end
            end
`ifdef CCFF_LOADER_READBACK_EN
            ST_VERIFY: begin
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == ROT_LAST) begin
                  r_state  <= ST_DONE;
                  r_clk_en <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  // fold in the tail bit being sampled this cycle
                  r_error  <= (crc16_step(w_crc_rb, ccff_tail) != w_crc_ld);
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed self-checking bench for ccff_loader with behavioural chain models.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ccff_loader;

`ifdef CCFF_LOADER_READBACK_EN
   localparam int V = 1;
`else
   localparam int V = 0;
`endif

   logic       prog_clk = 1'b0;
   logic       prog_reset = 1'b1;
   logic       start16 = 1'b0;
   logic       start12 = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;

   logic rdy16, head16, en16, busy16, done16, err16, tail16;
   logic rdy12, head12, en12, busy12, done12, err12, tail12;

   logic [15:0] chain16 = 16'h0000;
   logic [11:0] chain12 = 12'h000;
   logic [15:0] flip16 = 16'h0000;

   int checks = 0;
   int errors = 0;

   always #5 prog_clk = ~prog_clk;

   ccff_loader #(.CHAIN_LEN(16)) u_dut16 (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start16),
      .din(din), .din_valid(din_valid), .din_ready(rdy16),
      .ccff_head(head16), .ccff_tail(tail16), .ccff_clk_en(en16),
      .busy(busy16), .done(done16), .error(err16)
   );

   ccff_loader #(.CHAIN_LEN(12)) u_dut12 (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start12),
      .din(din), .din_valid(din_valid), .din_ready(rdy12),
      .ccff_head(head12), .ccff_tail(tail12), .ccff_clk_en(en12),
      .busy(busy12), .done(done12), .error(err12)
   );

   // Chain models: first bit shifted ends up at the tail end (MSB)
   always @(posedge prog_clk) begin
      if (en16) chain16 <= {chain16[14:0], head16} ^ flip16;
      if (en12) chain12 <= {chain12[10:0], head12};
   end
   assign tail16 = chain16[15];
   assign tail12 = chain12[11];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one load from the current cycle (posedge+1). Cycle 0 = start high.
   task automatic run_load(input bit sel12, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nb, input int stall_lo,
                           input int stall_hi, input int restart_at, input int flip_at,
                           output int nshift, output logic [15:0] seq, output int first_cyc,
                           output int done_cyc, output int nacc, output int gaps);
      logic [7:0] bytes [3];
      int idx;
      logic acc, en, hd, dn, rdy;
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
      idx = 0; nshift = 0; seq = 16'h0; first_cyc = -1; done_cyc = -1; nacc = 0; gaps = 0;
      if (sel12) start12 = 1'b1; else start16 = 1'b1;
      din_valid = 1'b0;
      @(posedge prog_clk); #1;
      start12 = 1'b0; start16 = 1'b0;
      for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
         din_valid = (idx < nb) && !(cyc >= stall_lo && cyc <= stall_hi);
         din = bytes[(idx < 3) ? idx : 2];
         if (cyc == restart_at) begin
            if (sel12) start12 = 1'b1; else start16 = 1'b1;
         end
         if (cyc == flip_at) flip16 = 16'h0100;
         en  = sel12 ? en12   : en16;
         hd  = sel12 ? head12 : head16;
         dn  = sel12 ? done12 : done16;
         rdy = sel12 ? rdy12  : rdy16;
         if (dn) begin
            done_cyc = cyc;
         end else if (en) begin
            if (nshift == 0) first_cyc = cyc;
            seq = {seq[14:0], hd};
            nshift++;
         end else if (nshift > 0) begin
            gaps++;
         end
         acc = din_valid && rdy;
         @(posedge prog_clk); #1;
         start12 = 1'b0; start16 = 1'b0; flip16 = 16'h0;
         if (acc) begin
            idx++;
            nacc++;
         end
      end
      din_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ns, fc, dc, na, gp;
      logic [15:0] sq;

      // Reset state
      @(posedge prog_clk); #1;
      chk("rst_ready", 32'(rdy16), 32'd0);
      chk("rst_head",  32'(head16), 32'd0);
      chk("rst_clken", 32'(en16), 32'd0);
      chk("rst_busy",  32'(busy16), 32'd0);
      chk("rst_done",  32'(done16), 32'd0);
      chk("rst_error", 32'(err16), 32'd0);
      prog_reset = 1'b0;
      @(posedge prog_clk); #1;
      chk("idle_ready", 32'({rdy16, rdy12, busy12}), 32'd0);

      // 1: CHAIN_LEN=16, A5 3C continuous
      run_load(1'b0, 8'hA5, 8'h3C, 8'h00, 2, -1, -1, -1, -1, ns, sq, fc, dc, na, gp);
      chk("t1_nshift", 32'(ns), 32'(16 + 16*V));
      chk("t1_seq",    32'(sq), 32'hA53C);
      chk("t1_first",  32'(fc), 32'd2);
      chk("t1_done",   32'(dc), 32'(18 + 16*V));
      chk("t1_gaps",   32'(gp), 32'd0);
      chk("t1_chain",  32'(chain16), 32'hA53C);
      chk("t1_status", 32'({busy16, rdy16, en16, err16}), 32'd0);

      // 2: CHAIN_LEN=12, FF 0F (+ extra AA offered)
      run_load(1'b1, 8'hFF, 8'h0F, 8'hAA, 3, -1, -1, -1, -1, ns, sq, fc, dc, na, gp);
      chk("t2_nshift", 32'(ns), 32'(12 + 12*V));
      chk("t2_seq",    32'(sq[11:0]), 32'h0FF0);
      chk("t2_done",   32'(dc), 32'(14 + 12*V));
      chk("t2_nacc",   32'(na), 32'd2);
      chk("t2_chain",  32'(chain12), 32'h0FF0);
      chk("t2_status", 32'({busy12, rdy12, en12, err12}), 32'd0);

      // 3: din_valid low mid-load, 5 idle chain cycles
      run_load(1'b0, 8'hA5, 8'h3C, 8'h00, 2, 2, 13, -1, -1, ns, sq, fc, dc, na, gp);
      chk("t3_nshift", 32'(ns), 32'(16 + 16*V));
      chk("t3_gaps",   32'(gp), 32'd5);
      chk("t3_done",   32'(dc), 32'(23 + 16*V));
      chk("t3_chain",  32'(chain16), 32'hA53C);

      // 4: start pulsed during LOAD is ignored
      run_load(1'b0, 8'h5A, 8'hC3, 8'h00, 2, -1, -1, 5, -1, ns, sq, fc, dc, na, gp);
      chk("t4_nshift", 32'(ns), 32'(16 + 16*V));
      chk("t4_seq",    32'(sq), 32'h5AC3);
      chk("t4_done",   32'(dc), 32'(18 + 16*V));
      chk("t4_chain",  32'(chain16), 32'h5AC3);

      // 5: reset while bit 7 is on the chain head, then a fresh load
      start16 = 1'b1; din = 8'h96; din_valid = 1'b1;
      @(posedge prog_clk); #1;
      start16 = 1'b0;
      for (int c = 2; c <= 9; c++) begin
         @(posedge prog_clk); #1;
      end
      chk("t5_midload", 32'({busy16, en16}), 32'h3);
      prog_reset = 1'b1; din_valid = 1'b0;
      @(posedge prog_clk); #1;
      chk("t5_rst_outs", 32'({rdy16, head16, en16, busy16, done16, err16}), 32'd0);
      prog_reset = 1'b0;
      @(posedge prog_clk); #1;
      run_load(1'b0, 8'h12, 8'h34, 8'h00, 2, -1, -1, -1, -1, ns, sq, fc, dc, na, gp);
      chk("t5_nshift", 32'(ns), 32'(16 + 16*V));
      chk("t5_seq",    32'(sq), 32'h1234);
      chk("t5_done",   32'(dc), 32'(18 + 16*V));
      chk("t5_chain",  32'(chain16), 32'h1234);
      chk("t5_error",  32'(err16), 32'd0);

`ifdef CCFF_LOADER_READBACK_EN
      // 6: corrupt one chain flop during VERIFY
      run_load(1'b0, 8'h12, 8'h34, 8'h00, 2, -1, -1, -1, 20, ns, sq, fc, dc, na, gp);
      chk("t6_done",  32'(dc), 32'd34);
      chk("t6_error", 32'(err16), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
